// File: rtl/dmem_responder.sv
// Single-port data-memory responder: byte/half/word loads and stores over a valid/ready
// request/response handshake. Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_wr_in,
    input  logic [31:0] req_addr_in,
    input  logic [1:0]  req_size_in,
    input  logic [31:0] req_wdata_in,
    output logic        rsp_valid_out,
    input  logic        rsp_ready_in,
    output logic [31:0] rsp_rdata_out,
    output logic        rsp_err_out
);
    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(4 * DEPTH_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_MERGE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [1:0]    r_state;
    logic          r_wr;
    logic [1:0]    r_size;
    logic [1:0]    r_boff;
    logic [AW-1:0] r_widx;
    logic [15:0]   r_wdata;
    logic [31:0]   r_old;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_below;
    logic [31:0]   w_off;
    logic [2:0]    w_sz;
    logic [32:0]   w_end;
    logic          w_mis;
    logic          w_err;
    logic          w_accept;
    logic          w_wr_word;
    logic          w_wr_merge;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_shift;
    logic [31:0]   w_ld;
    logic [31:0]   w_lmask;
    logic [31:0]   w_ldata;
    logic [31:0]   w_merged;

    // Borrow out of the subtraction flags addresses below the window.
    assign {w_below, w_off} = {1'b0, req_addr_in} - {1'b0, BASE_ADDR};
    assign w_sz  = (req_size_in == 2'b00) ? 3'd1 : (req_size_in == 2'b01) ? 3'd2 : 3'd4;
    assign w_end = {1'b0, w_off} + {30'b0, w_sz};

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_mis = ((req_size_in == 2'b01) && w_off[0]) ||
                   ((req_size_in == 2'b10) && (w_off[1:0] != 2'b00));
`else
    // Only a half-word straddling two words is unservable.
    assign w_mis = (req_size_in == 2'b01) && (w_off[1:0] == 2'b11);
`endif

    assign w_err      = (req_size_in == 2'b11) || w_below || (w_end > MEM_BYTES) || w_mis;
    assign w_accept   = req_valid_in && req_ready_out;
    assign w_wr_word  = w_accept && !w_err && req_wr_in && (req_size_in == 2'b10);
    assign w_wr_merge = (r_state == S_MERGE);

    assign w_rd_word = r_mem[r_widx];
    assign w_shift   = w_rd_word >> {r_boff, 3'b000};
    assign w_ld      = (r_size == 2'b00) ? {24'b0, w_shift[7:0]} :
                       (r_size == 2'b01) ? {16'b0, w_shift[15:0]} : w_shift;

    assign w_lmask  = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << {r_boff, 3'b000};
    assign w_ldata  = ((r_size == 2'b00) ? {24'b0, r_wdata[7:0]} : {16'b0, r_wdata})
                      << {r_boff, 3'b000};
    assign w_merged = (r_old & ~w_lmask) | w_ldata;

    // Storage is deliberately outside reset; an async reset drops the FSM out of MERGE before any write.
    always_ff @(posedge clk) begin
        if (w_wr_word)
            r_mem[w_off[AW+1:2]] <= req_wdata_in;
        else if (w_wr_merge)
            r_mem[r_widx] <= w_merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wr    <= 1'b0;
            r_size  <= 2'b00;
            r_boff  <= 2'b00;
            r_widx  <= '0;
            r_wdata <= 16'h0;
            r_old   <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_in) begin
                        r_wr    <= req_wr_in;
                        r_size  <= req_size_in;
                        r_boff  <= (req_size_in == 2'b10) ? 2'b00 : w_off[1:0];
                        r_widx  <= w_off[AW+1:2];
                        r_wdata <= req_wdata_in[15:0];
                        r_err   <= w_err;
                        r_rdata <= 32'h0;
                        r_state <= (w_err || (req_wr_in && (req_size_in == 2'b10))) ? S_RESP : S_READ;
                    end
                end
                S_READ: begin
                    if (r_wr) begin
                        r_old   <= w_rd_word;
                        r_state <= S_MERGE;
                    end else begin
                        r_rdata <= w_ld;
                        r_state <= S_RESP;
                    end
                end
                S_MERGE: r_state <= S_RESP;
                S_RESP:  if (rsp_ready_in) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready_out = (r_state == S_IDLE);
    assign rsp_valid_out = (r_state == S_RESP);
    assign rsp_rdata_out = r_rdata;
    assign rsp_err_out   = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, data, error, backpressure and reset-abort cases.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_wr_in;
    logic [31:0] req_addr_in;
    logic [1:0]  req_size_in;
    logic [31:0] req_wdata_in;
    logic        rsp_valid_out;
    logic        rsp_ready_in;
    logic [31:0] rsp_rdata_out;
    logic        rsp_err_out;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .req_wr_in     (req_wr_in),
        .req_addr_in   (req_addr_in),
        .req_size_in   (req_size_in),
        .req_wdata_in  (req_wdata_in),
        .rsp_valid_out (rsp_valid_out),
        .rsp_ready_in  (rsp_ready_in),
        .rsp_rdata_out (rsp_rdata_out),
        .rsp_err_out   (rsp_err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request; lat counts edges from the accepting edge (=1) until rsp_valid_out is seen.
    task automatic xact(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
        @(negedge clk);
        req_valid_in = 1'b1; req_wr_in = wr; req_addr_in = addr;
        req_size_in = sz; req_wdata_in = wd; rsp_ready_in = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            req_valid_in = 1'b0;
            lat++;
        end while (!rsp_valid_out && lat < 10);
        rd = rsp_rdata_out;
        er = rsp_err_out;
        @(negedge clk); rsp_ready_in = 1'b1;
        @(posedge clk); #1; rsp_ready_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        rst = 1'b1; req_valid_in = 1'b0; req_wr_in = 1'b0; req_addr_in = 32'h0;
        req_size_in = 2'b00; req_wdata_in = 32'h0; rsp_ready_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, rsp_valid_out}, 32'd0);
        chk("rst_err",   {31'b0, rsp_err_out},   32'd0);
        chk("rst_rdata", rsp_rdata_out,          32'h0);
        chk("rst_ready", {31'b0, req_ready_out}, 32'd1);
        rst = 1'b0;

        // word store then word load
        xact(1'b1, 32'h10, 2'b10, 32'hDEAD_BEEF, rd, er, lat);
        chk("st_w_lat",   32'(lat), 32'd1);
        chk("st_w_err",   {31'b0, er}, 32'd0);
        chk("st_w_rdata", rd, 32'h0);
        xact(1'b0, 32'h10, 2'b10, 32'h0, rd, er, lat);
        chk("ld_w_data", rd, 32'hDEAD_BEEF);
        chk("ld_w_err",  {31'b0, er}, 32'd0);
        chk("ld_w_lat",  32'(lat), 32'd2);

        // byte store via read-modify-write
        xact(1'b1, 32'h12, 2'b00, 32'h0000_005A, rd, er, lat);
        chk("st_b_lat", 32'(lat), 32'd3);
        chk("st_b_err", {31'b0, er}, 32'd0);
        xact(1'b0, 32'h10, 2'b10, 32'h0, rd, er, lat);
        chk("ld_w_merged", rd, 32'hDE5A_BEEF);
        xact(1'b0, 32'h13, 2'b00, 32'h0, rd, er, lat);
        chk("ld_b_13", rd, 32'h0000_00DE);
        chk("ld_b_lat", 32'(lat), 32'd2);

        // out of range
        xact(1'b0, 32'h1000, 2'b10, 32'h0, rd, er, lat);
        chk("oor_err",   {31'b0, er}, 32'd1);
        chk("oor_rdata", rd, 32'h0);
        chk("oor_lat",   32'(lat), 32'd1);
        xact(1'b1, 32'h0FFE, 2'b10, 32'h1234_5678, rd, er, lat);
        chk("oor_st_err", {31'b0, er}, 32'd1);
        xact(1'b0, 32'h10, 2'b10, 32'h0, rd, er, lat);
        chk("oor_unchanged", rd, 32'hDE5A_BEEF);
        xact(1'b0, 32'h10, 2'b11, 32'h0, rd, er, lat);
        chk("size11_err", {31'b0, er}, 32'd1);

        // misalignment
        xact(1'b0, 32'h11, 2'b10, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_w_err",   {31'b0, er}, 32'd1);
        chk("mis_w_rdata", rd, 32'h0);
`else
        chk("mis_w_err",   {31'b0, er}, 32'd0);
        chk("mis_w_rdata", rd, 32'hDE5A_BEEF);
`endif
        xact(1'b0, 32'h13, 2'b01, 32'h0, rd, er, lat);
        chk("cross_h_err", {31'b0, er}, 32'd1);
        chk("cross_h_lat", 32'(lat), 32'd1);
        xact(1'b0, 32'h11, 2'b01, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("h_off1_err", {31'b0, er}, 32'd1);
`else
        chk("h_off1_data", rd, 32'h0000_5ABE);
`endif

        // half store into upper lanes
        xact(1'b1, 32'h24, 2'b10, 32'hAABB_CCDD, rd, er, lat);
        xact(1'b1, 32'h26, 2'b01, 32'h0000_1234, rd, er, lat);
        chk("st_h_lat", 32'(lat), 32'd3);
        xact(1'b0, 32'h24, 2'b10, 32'h0, rd, er, lat);
        chk("st_h_merged", rd, 32'h1234_CCDD);

        // backpressure: hold response for 5 cycles
        @(negedge clk);
        req_valid_in = 1'b1; req_wr_in = 1'b0; req_addr_in = 32'h10; req_size_in = 2'b00;
        @(posedge clk); #1; req_valid_in = 1'b0;
        @(posedge clk); #1;
        chk("bp_valid0", {31'b0, rsp_valid_out}, 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'b0, rsp_valid_out}, 32'd1);
            chk("bp_rdata", rsp_rdata_out, 32'h0000_00EF);
            chk("bp_err",   {31'b0, rsp_err_out}, 32'd0);
            chk("bp_ready", {31'b0, req_ready_out}, 32'd0);
        end
        @(negedge clk); rsp_ready_in = 1'b1;
        @(posedge clk); #1; rsp_ready_in = 1'b0;
        chk("bp_done_valid", {31'b0, rsp_valid_out}, 32'd0);
        chk("bp_done_ready", {31'b0, req_ready_out}, 32'd1);

        // reset during MERGE aborts the write
        xact(1'b1, 32'h20, 2'b10, 32'h1122_3344, rd, er, lat);
        @(negedge clk);
        req_valid_in = 1'b1; req_wr_in = 1'b1; req_addr_in = 32'h20;
        req_size_in = 2'b01; req_wdata_in = 32'h0000_BEEF;
        @(posedge clk); #1; req_valid_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("rstm_valid", {31'b0, rsp_valid_out}, 32'd0);
        chk("rstm_ready", {31'b0, req_ready_out}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        xact(1'b0, 32'h20, 2'b10, 32'h0, rd, er, lat);
        chk("rstm_mem", rd, 32'h1122_3344);
        xact(1'b0, 32'h10, 2'b10, 32'h0, rd, er, lat);
        chk("rst_keeps_mem", rd, 32'hDE5A_BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
